// File: rtl/cpu_pkg.sv
// Shared types for the accumulator CPU sequencer: opcodes, phase encoding
// and the memory-read opcode helper.
package cpu_pkg;

  localparam int unsigned PHASE_W      = 3;
  localparam int unsigned STATE_W      = PHASE_W + 1;
  localparam int unsigned MAX_WAIT_DEF = 15;

  typedef enum logic [PHASE_W-1:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_t;

  // HALTED sits outside the 8-phase ring, flagged by the extra top bit.
  typedef enum logic [STATE_W-1:0] {
    INST_ADDR  = 4'd0,
    INST_FETCH = 4'd1,
    INST_LOAD  = 4'd2,
    IDLE       = 4'd3,
    OP_ADDR    = 4'd4,
    OP_FETCH   = 4'd5,
    ALU_OP     = 4'd6,
    STORE      = 4'd7,
    HALTED     = 4'd8
  } phase_t;

  function automatic logic is_mrd(input opcode_t op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

endpackage

// File: rtl/cpu_wait_timer.sv
// Saturating memory wait-state counter; flags the cycle on which a stalled
// fetch reaches MAX_WAIT wait cycles.
module cpu_wait_timer #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic hold,
  output logic expired_c
);

  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0] count;

  // Any cycle that is not a stalled fetch is a phase advance, so it clears.
  always_ff @(posedge clk) begin
    if (rst || !hold) begin
      count <= '0;
    end else if (count != CNT_W'(MAX_WAIT)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired_c = hold && (count >= CNT_W'(MAX_WAIT - 1));

endmodule

// File: rtl/cpu_sequencer.sv
// 8-phase fetch/execute sequencer for the accumulator CPU with fetch
// wait-states, timeout and halt. `SINGLE_STEP_EN adds step/step_mode.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   opcode,
  input  logic         zero,
  input  logic         mem_ready,
`ifdef SINGLE_STEP_EN
  input  logic         step,
  input  logic         step_mode,
`endif
  output logic         addr_sel,
  output logic         mem_en,
  output logic         mem_we,
  output logic         ir_load,
  output logic         pc_en,
  output logic         pc_load,
  output logic         alu_en,
  output logic         accumulator_load,
  output logic         accumulator_control,
  output logic [2:0]   phase,
  output logic         halted,
  output logic         timeout
);

  phase_t  state_q, state_d;
  logic    timeout_q, timeout_d;
  opcode_t op;
  logic    mrd_c, alu_op_c, acc_path_c;
  logic    hold_c, expired_c;

  assign op         = opcode_t'(opcode);
  assign mrd_c      = is_mrd(op);
  assign alu_op_c   = (op == ADD) || (op == AND) || (op == XOR);
  assign acc_path_c = (op == LDA) || (op == STO);
  assign hold_c     = ((state_q == INST_FETCH) || (state_q == OP_FETCH)) && !mem_ready;

  cpu_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
    .clk       (clk),
    .rst       (rst),
    .hold      (hold_c),
    .expired_c (expired_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= INST_ADDR;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timeout_q <= timeout_d;
    end
  end

  // Next phase and phase-timed strobes; opcode is only consulted from OP_ADDR on.
  always_comb begin
    state_d             = state_q;
    timeout_d           = timeout_q;
    addr_sel            = 1'b0;
    mem_en              = 1'b0;
    mem_we              = 1'b0;
    ir_load             = 1'b0;
    pc_en               = 1'b0;
    pc_load             = 1'b0;
    alu_en              = 1'b0;
    accumulator_load    = 1'b0;
    accumulator_control = 1'b0;
    halted              = 1'b0;
    case (state_q)
      INST_ADDR: begin
        addr_sel = 1'b1;
`ifdef SINGLE_STEP_EN
        if (!step_mode || step) state_d = INST_FETCH;
`else
        state_d = INST_FETCH;
`endif
      end
      INST_FETCH: begin
        addr_sel = 1'b1;
        mem_en   = 1'b1;
        if (mem_ready) begin
          state_d = INST_LOAD;
        end else if (expired_c) begin
          state_d   = HALTED;
          timeout_d = 1'b1;
        end
      end
      INST_LOAD: begin
        addr_sel = 1'b1;
        mem_en   = 1'b1;
        ir_load  = 1'b1;
        state_d  = IDLE;
      end
      IDLE: begin
        addr_sel = 1'b1;
        mem_en   = 1'b1;
        ir_load  = 1'b1;
        state_d  = OP_ADDR;
      end
      OP_ADDR: begin
        if (op == HLT) begin
          state_d = HALTED;
        end else begin
          pc_en   = 1'b1;
          state_d = OP_FETCH;
        end
      end
      OP_FETCH: begin
        mem_en = mrd_c;
        if (mem_ready) begin
          state_d = ALU_OP;
        end else if (expired_c) begin
          state_d   = HALTED;
          timeout_d = 1'b1;
        end
      end
      ALU_OP: begin
        mem_en              = mrd_c;
        accumulator_load    = mrd_c;
        alu_en              = alu_op_c;
        pc_en               = (op == SKZ) && zero;
        pc_load             = (op == JMP);
        accumulator_control = acc_path_c;
        state_d             = STORE;
      end
      STORE: begin
        mem_en              = mrd_c;
        accumulator_load    = mrd_c;
        alu_en              = alu_op_c;
        pc_load             = (op == JMP);
        mem_we              = (op == STO);
        accumulator_control = acc_path_c;
        state_d             = INST_ADDR;
      end
      HALTED: begin
        halted = 1'b1;
`ifdef SINGLE_STEP_EN
        if (step_mode && step) state_d = INST_ADDR;
`endif
      end
      default: state_d = INST_ADDR;
    endcase
  end

  assign phase   = state_q[PHASE_W-1:0];
  assign timeout = timeout_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed scoreboard bench for cpu_sequencer: expected strobe vectors are
// queued as each cycle is driven and checked mid-cycle against the DUT.
module tb_cpu_sequencer;

  localparam logic [2:0] OP_HLT = 3'd0, OP_SKZ = 3'd1, OP_ADD = 3'd2, OP_AND = 3'd3,
                         OP_XOR = 3'd4, OP_LDA = 3'd5, OP_STO = 3'd6, OP_JMP = 3'd7;
  localparam int PH_HALT = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] opcode = OP_ADD;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       addr_sel, mem_en, mem_we, ir_load, pc_en, pc_load, alu_en;
  logic       accumulator_load, accumulator_control, halted, timeout;
  logic [2:0] phase;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [13:0] v;
    string       tag;
  } sb_t;
  sb_t sb[$];

  cpu_sequencer dut (
    .clk                 (clk),
    .rst                 (rst),
    .opcode              (opcode),
    .zero                (zero),
    .mem_ready           (mem_ready),
`ifdef SINGLE_STEP_EN
    .step                (1'b0),
    .step_mode           (1'b0),
`endif
    .addr_sel            (addr_sel),
    .mem_en              (mem_en),
    .mem_we              (mem_we),
    .ir_load             (ir_load),
    .pc_en               (pc_en),
    .pc_load             (pc_load),
    .alu_en              (alu_en),
    .accumulator_load    (accumulator_load),
    .accumulator_control (accumulator_control),
    .phase               (phase),
    .halted              (halted),
    .timeout             (timeout)
  );

  always #5 clk = ~clk;

  // Vector: {addr_sel, mem_en, mem_we, ir_load, pc_en, pc_load, alu_en,
  //          acc_load, acc_ctrl, halted, timeout, phase[2:0]}
  function automatic logic [13:0] exp_vec(input int ph, input logic [2:0] op,
                                          input logic z, input logic to);
    logic mrd, alu, accp;
    if (ph == PH_HALT) return {9'b0, 1'b1, to, 3'b000};
    mrd  = op inside {OP_ADD, OP_AND, OP_XOR, OP_LDA};
    alu  = op inside {OP_ADD, OP_AND, OP_XOR};
    accp = op inside {OP_LDA, OP_STO};
    return {ph <= 3,
            (ph >= 1 && ph <= 3) || (ph >= 5 && mrd),
            ph == 7 && op == OP_STO,
            ph == 2 || ph == 3,
            (ph == 4 && op != OP_HLT) || (ph == 6 && op == OP_SKZ && z),
            (ph == 6 || ph == 7) && op == OP_JMP,
            (ph == 6 || ph == 7) && alu,
            (ph == 6 || ph == 7) && mrd,
            (ph == 6 || ph == 7) && accp,
            1'b0, to, 3'(ph)};
  endfunction

  task automatic check();
    sb_t         e;
    logic [13:0] obs;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty obs=none exp=entry");
      return;
    end
    e   = sb.pop_front();
    obs = {addr_sel, mem_en, mem_we, ir_load, pc_en, pc_load, alu_en,
           accumulator_load, accumulator_control, halted, timeout, phase};
    if (e.v[4]) obs[2:0] = 3'b000;
    assert (obs === e.v) else begin
      bad++;
      $error("FAIL %s t=%0t obs=%b exp=%b", e.tag, $time, obs, e.v);
    end
  endtask

  task automatic run(input logic [2:0] op, input logic z, input logic rdy, input logic r,
                     input int ph, input logic to, input string tag);
    sb_t e;
    opcode = op; zero = z; mem_ready = rdy; rst = r;
    e.v = exp_vec(ph, op, z, to);
    e.tag = tag;
    sb.push_back(e);
    @(negedge clk);
    check();
    @(posedge clk); #1;
  endtask

  // One full instruction with ready memory; junk opcode in phases 0-3.
  task automatic instr(input logic [2:0] op, input logic z, input string tag);
    for (int p = 0; p < 8; p++)
      run((p < 4) ? 3'($urandom) : op, z, 1'b1, 1'b0, p, 1'b0, tag);
  endtask

  initial begin
    run(OP_ADD, 1'b0, 1'b1, 1'b1, 0, 1'b0, "reset");
    run(OP_ADD, 1'b0, 1'b1, 1'b1, 0, 1'b0, "reset");

    instr(OP_ADD, 1'b0, "add");
    instr(OP_ADD, 1'b1, "add2");
    instr(OP_STO, 1'b0, "sto");
    instr(OP_LDA, 1'b0, "lda");
    instr(OP_AND, 1'b0, "and");
    instr(OP_XOR, 1'b0, "xor");
    instr(OP_SKZ, 1'b1, "skz_z1");
    instr(OP_SKZ, 1'b0, "skz_z0");
    instr(OP_JMP, 1'b1, "jmp");

    // Instruction fetch stalled for 3 cycles.
    run(OP_ADD, 1'b0, 1'b1, 1'b0, 0, 1'b0, "iwait");
    for (int i = 0; i < 3; i++) run(OP_ADD, 1'b0, 1'b0, 1'b0, 1, 1'b0, "iwait_hold");
    for (int p = 1; p < 8; p++) run(OP_ADD, 1'b0, 1'b1, 1'b0, p, 1'b0, "iwait");

    // Operand fetch stalled for 2 cycles.
    for (int p = 0; p < 5; p++) run(OP_LDA, 1'b0, 1'b1, 1'b0, p, 1'b0, "owait");
    for (int i = 0; i < 2; i++) run(OP_LDA, 1'b0, 1'b0, 1'b0, 5, 1'b0, "owait_hold");
    for (int p = 5; p < 8; p++) run(OP_LDA, 1'b0, 1'b1, 1'b0, p, 1'b0, "owait");

    // Reset raised in ALU_OP.
    for (int p = 0; p < 6; p++) run(OP_ADD, 1'b0, 1'b1, 1'b0, p, 1'b0, "rst_mid");
    run(OP_ADD, 1'b0, 1'b1, 1'b1, 6, 1'b0, "rst_mid");
    instr(OP_ADD, 1'b0, "after_rst_mid");

    // Fetch timeout after 15 stalled cycles.
    run(OP_ADD, 1'b0, 1'b1, 1'b0, 0, 1'b0, "timeout");
    for (int i = 0; i < 15; i++) run(OP_ADD, 1'b0, 1'b0, 1'b0, 1, 1'b0, "timeout_hold");
    for (int i = 0; i < 3; i++) run(OP_ADD, 1'b0, 1'b1, 1'b0, PH_HALT, 1'b1, "timeout_halt");
    run(OP_ADD, 1'b0, 1'b1, 1'b1, PH_HALT, 1'b1, "timeout_rst");
    instr(OP_ADD, 1'b0, "after_timeout");

    // HLT halts from OP_ADDR and stays halted until reset.
    for (int p = 0; p < 5; p++) run(OP_HLT, 1'b0, 1'b1, 1'b0, p, 1'b0, "hlt");
    for (int i = 0; i < 4; i++) run(OP_HLT, 1'b1, 1'b1, 1'b0, PH_HALT, 1'b0, "hlt_halt");
    run(OP_JMP, 1'b0, 1'b1, 1'b0, PH_HALT, 1'b0, "hlt_halt");
    run(OP_ADD, 1'b0, 1'b1, 1'b1, PH_HALT, 1'b0, "hlt_rst");
    instr(OP_STO, 1'b0, "after_hlt");

    if (sb.size() != 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_leftover obs=%0d exp=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog obs=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
